// File: rtl/dmem_arb_pkg.sv
// Shared owner-state encodings, select codes and default arbitration limits
// for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int CNT_W            = 4;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int BURST_MAX_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE     = 2'd1,
    ST_AUX      = 2'd2,
    ST_AUX_LOCK = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CORE = 2'd1,
    SEL_AUX  = 2'd2
  } sel_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear priority over increment.
// One-cycle update latency; holds at limit while inc stays high.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt
);

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt < limit)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (core vs loader/debug), zero-wait single-cycle grant.
// Losers see no ack and must hold; define DMEM_ARB_LOCK_EN for locked aux bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int BURST_MAX    = BURST_MAX_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_ack,
  output logic        core_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic        aux_lock,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ack,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  owner
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);

  owner_e           state_q;
  owner_e           state_d;
  sel_e             sel;
  logic [CNT_W-1:0] starve_cnt;
  logic             lock_hold;
  logic             starved;
  logic             starve_inc;
  logic             starve_clr;

`ifdef DMEM_ARB_LOCK_EN
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] burst_d;
  logic [CNT_W-1:0] burst_inc;

  assign lock_hold = (state_q == ST_AUX_LOCK) && aux_req;
  assign burst_inc = burst_q + CNT_W'(1);
`else
  localparam int unused_burst_max = BURST_MAX;
  logic unused_lock;

  assign unused_lock = aux_lock;
  assign lock_hold   = 1'b0;
`endif

  assign starved = (starve_cnt == STARVE_LIM) && aux_req;

  // Selection; nothing is granted while Reset is high so no access escapes.
  always_comb begin
    sel = SEL_NONE;
    if (!Reset) begin
      if (lock_hold || starved) begin
        sel = SEL_AUX;
      end else if (core_req) begin
        sel = SEL_CORE;
      end else if (aux_req) begin
        sel = SEL_AUX;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    core_ack  = 1'b0;
    aux_ack   = 1'b0;
    case (sel)
      SEL_CORE: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_we;
        mem_re    = ~core_we;
        core_ack  = core_req;
      end
      SEL_AUX: begin
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
        mem_we    = aux_we;
        mem_re    = ~aux_we;
        aux_ack   = aux_req;
      end
      default: ;
    endcase
  end

  assign core_stall = core_req & ~core_ack & ~Reset;
  assign rdata      = (core_ack | aux_ack) ? mem_rdata : 32'd0;

  assign starve_inc = aux_req & ~aux_ack;
  assign starve_clr = aux_ack | ~aux_req;

  sat_counter #(
    .W (CNT_W)
  ) u_starve_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .limit (STARVE_LIM),
    .cnt   (starve_cnt)
  );

  always_comb begin
    state_d = ST_IDLE;
`ifdef DMEM_ARB_LOCK_EN
    burst_d = '0;
`endif
    if (core_ack) begin
      state_d = ST_CORE;
    end else if (aux_ack) begin
      state_d = ST_AUX;
`ifdef DMEM_ARB_LOCK_EN
      // Burst length counts the access just performed; leave once it hits the cap.
      if (aux_lock) begin
        if (state_q == ST_AUX_LOCK) begin
          if (burst_inc < BURST_LIM) begin
            state_d = ST_AUX_LOCK;
            burst_d = burst_inc;
          end
        end else if (BURST_LIM > CNT_W'(1)) begin
          state_d = ST_AUX_LOCK;
          burst_d = CNT_W'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`endif

  assign owner = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        core_req, core_we, aux_req, aux_we, aux_lock;
  logic [31:0] core_addr, core_wdata, aux_addr, aux_wdata;
  logic        core_ack, core_stall, aux_ack, mem_we, mem_re;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  logic [31:0] mem [64];
  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge Clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  dmem_arbiter #(.STARVE_LIMIT(4), .BURST_MAX(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_stall(core_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_lock(aux_lock), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_ack(aux_ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    aux_req = 0; aux_we = 0; aux_lock = 0; aux_addr = 0; aux_wdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bit exp_aux;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[32'h10 >> 2] = 32'hCAFE0001;
    idle_inputs();
    Reset = 1'b1;
    #2;

    // Reset cycle with both requesters active: nothing may be granted.
    core_req = 1; aux_req = 1; aux_we = 1; aux_addr = 32'h3C; aux_wdata = 32'hDEAD0000;
    #1;
    chk("rst_core_ack", {31'd0, core_ack}, 32'd0);
    chk("rst_aux_ack", {31'd0, aux_ack}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_stall", {31'd0, core_stall}, 32'd0);
    tick();
    Reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("idle_rdata", rdata, 32'd0);
    chk("rst_no_write", mem[32'h3C >> 2], 32'd0);
    tick();

    // Core load with aux idle.
    core_req = 1; core_addr = 32'h10;
    #1;
    chk("lw_ack", {31'd0, core_ack}, 32'd1);
    chk("lw_rdata", rdata, 32'hCAFE0001);
    chk("lw_stall", {31'd0, core_stall}, 32'd0);
    chk("lw_re", {31'd0, mem_re}, 32'd1);
    tick();
    idle_inputs();
    #1;
    chk("lw_owner_next", {30'd0, owner}, 32'd1);
    chk("lw_rdata_noack", rdata, 32'd0);
    tick();

    // Aux store, then core reads it back.
    aux_req = 1; aux_we = 1; aux_addr = 32'h20; aux_wdata = 32'h12345678;
    #1;
    chk("sw_aux_ack", {31'd0, aux_ack}, 32'd1);
    chk("sw_mem_we", {31'd0, mem_we}, 32'd1);
    chk("sw_mem_addr", mem_addr, 32'h20);
    tick();
    idle_inputs();
    core_req = 1; core_addr = 32'h20;
    #1;
    chk("sw_owner", {30'd0, owner}, 32'd2);
    chk("rb_rdata", rdata, 32'h12345678);
    tick();
    idle_inputs();
    tick();

    // Both held: core wins 4 cycles, aux every 5th via starvation.
    core_req = 1; core_addr = 32'h10;
    aux_req = 1; aux_addr = 32'h30;
    for (int c = 0; c < 10; c++) begin
      exp_aux = (c % 5) == 4;
      #1;
      chk("starve_core_ack", {31'd0, core_ack}, {31'd0, !exp_aux});
      chk("starve_aux_ack", {31'd0, aux_ack}, {31'd0, exp_aux});
      chk("starve_stall", {31'd0, core_stall}, {31'd0, exp_aux});
      if (exp_aux) chk("starve_addr", mem_addr, 32'h30);
      else chk("starve_rdata", rdata, 32'hCAFE0001);
      tick();
    end
    idle_inputs();
    tick();

`ifdef DMEM_ARB_LOCK_EN
    // Locked burst of aux writes: 8 acks, then core gets in.
    k = 0;
    aux_req = 1; aux_we = 1; aux_lock = 1;
    for (int c = 0; c < 9; c++) begin
      aux_addr = 32'h40 + 32'(k) * 4; aux_wdata = 32'hA0000000 + 32'(k);
      if (c > 0) core_req = 1;
      core_addr = 32'h10;
      #1;
      if (c == 1) chk("lock_owner", {30'd0, owner}, 32'd3);
      chk("lock_aux_ack", {31'd0, aux_ack}, {31'd0, c < 8});
      chk("lock_core_ack", {31'd0, core_ack}, {31'd0, c == 8});
      if (c >= 1 && c < 8) chk("lock_stall", {31'd0, core_stall}, 32'd1);
      if (c < 8) k++;
      tick();
    end
    idle_inputs();
    #1;
    chk("lock_owner_after", {30'd0, owner}, 32'd1);
    chk("lock_last_write", mem[(32'h40 >> 2) + 7], 32'hA0000007);
    tick();
`else
    // aux_lock has no effect: core regains the memory right away.
    aux_req = 1; aux_we = 1; aux_lock = 1; aux_addr = 32'h40; aux_wdata = 32'hA0000000;
    #1;
    chk("nolock_aux_ack", {31'd0, aux_ack}, 32'd1);
    tick();
    aux_addr = 32'h44; aux_wdata = 32'hA0000001;
    core_req = 1; core_addr = 32'h10;
    #1;
    chk("nolock_owner", {30'd0, owner}, 32'd2);
    chk("nolock_core_ack", {31'd0, core_ack}, 32'd1);
    chk("nolock_aux_wait", {31'd0, aux_ack}, 32'd0);
    tick();
    idle_inputs();
    tick();
`endif

    // Reset in the third cycle of an aux burst.
    aux_req = 1; aux_we = 1; aux_lock = 1; aux_addr = 32'h80; aux_wdata = 32'hB0000000;
    tick();
    aux_addr = 32'h84; aux_wdata = 32'hB0000001;
    core_req = 1; core_addr = 32'h10;
    tick();
    aux_addr = 32'h88; aux_wdata = 32'hB0000002;
    Reset = 1'b1;
    #1;
    chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_aux_ack", {31'd0, aux_ack}, 32'd0);
    chk("midrst_stall", {31'd0, core_stall}, 32'd0);
    tick();
    Reset = 1'b0;
    idle_inputs();
    core_req = 1; core_addr = 32'h10;
    #1;
    chk("midrst_owner", {30'd0, owner}, 32'd0);
    chk("midrst_core_ack", {31'd0, core_ack}, 32'd1);
    chk("midrst_no_write", mem[32'h88 >> 2], 32'd0);
    tick();
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
